// File: rtl/ip_issue_arb_pkg.sv
// ip_issue_arb_pkg
// Shared constants for the integer-pipeline issue arbiter and its 2-way
// grant picker.
//   ARB_SRC_R0 / ARB_SRC_R1       : source encoding carried on arb_ip_src
//   ARB_MODE_RR / ARB_MODE_FIXED  : PRIO_MODE encodings
//   STALL_CNT_W / STARVE_CNT_W    : counter widths
package ip_issue_arb_pkg;

    localparam logic ARB_SRC_R0 = 1'b0;
    localparam logic ARB_SRC_R1 = 1'b1;

    localparam int ARB_MODE_RR    = 0;
    localparam int ARB_MODE_FIXED = 1;

    localparam int STALL_CNT_W  = 16;
    // STARVE_LIMIT is bounded to 1..7, so three bits always suffice.
    localparam int STARVE_CNT_W = 3;

endpackage

// File: rtl/ip_arb_pick.sv
// ip_arb_pick
// Purely combinational 2-way grant decision. Reusable by any two-requester
// arbiter; holds no state of its own.
// Ports:
//   r0_valid_i, r1_valid_i : requester valids
//   mode_fixed_i           : 0 = round-robin, 1 = fixed priority r0
//   last_grant_i           : source of the most recent accept (round-robin)
//   starve_hit_i           : r1 has lost often enough to force a grant (fixed)
//   grant_o                : winning source (ARB_SRC_R0 / ARB_SRC_R1)
module ip_arb_pick
    import ip_issue_arb_pkg::*;
(
    input  logic r0_valid_i,
    input  logic r1_valid_i,
    input  logic mode_fixed_i,
    input  logic last_grant_i,
    input  logic starve_hit_i,
    output logic grant_o
);

    logic tie_to_r1;

    // NOTE: every output of a combinational block gets a value on every path
    // (default first), otherwise synthesis infers a latch.
    always_comb begin
        grant_o   = ARB_SRC_R0;
        tie_to_r1 = mode_fixed_i ? starve_hit_i : (last_grant_i == ARB_SRC_R0);
        if (r0_valid_i && r1_valid_i) begin
            grant_o = tie_to_r1 ? ARB_SRC_R1 : ARB_SRC_R0;
        end else if (r1_valid_i) begin
            grant_o = ARB_SRC_R1;
        end
        // With no requester valid the grant parks on r0.
    end

endmodule

// File: rtl/ip_issue_arb.sv
// ip_issue_arb
// Arbitrates the primary issue slot (r0) and the secondary/replay slot (r1)
// onto the single integer pipeline through a one-entry registered output
// stage: 1-cycle latency, one op per cycle, no bubble at full throughput.
// Ports:
//   clk, rst                   : clock, asynchronous active-low reset
//   r0_payload/valid/ready     : requester 0 handshake
//   r1_payload/valid/ready     : requester 1 handshake
//   flush                      : redirect; kills held entry, blocks accepts
//   arb_ip_payload/src/valid   : registered entry towards the pipeline
//   arb_ip_ready               : pipeline consumes the entry
//   arb_stall_cnt              : saturating count of cycles with a valid
//                                requester but no accept
module ip_issue_arb
    import ip_issue_arb_pkg::*;
#(
    parameter int PAYLOAD_W    = 256,
    parameter int PRIO_MODE    = ARB_MODE_RR,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PAYLOAD_W-1:0]   r0_payload,
    input  logic                   r0_valid,
    output logic                   r0_ready,
    input  logic [PAYLOAD_W-1:0]   r1_payload,
    input  logic                   r1_valid,
    output logic                   r1_ready,
    input  logic                   flush,
    output logic [PAYLOAD_W-1:0]   arb_ip_payload,
    output logic                   arb_ip_src,
    output logic                   arb_ip_valid,
    input  logic                   arb_ip_ready,
    output logic [STALL_CNT_W-1:0] arb_stall_cnt
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);
    localparam logic                    MODE_FIXED = (PRIO_MODE == ARB_MODE_FIXED);

    logic [PAYLOAD_W-1:0]    payload_q, payload_d;
    logic                    src_q, src_d;
    logic                    valid_q, valid_d;
    logic                    last_grant_q, last_grant_d;
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
    logic [STALL_CNT_W-1:0]  stall_q, stall_d;

    logic load_en;
    logic arb_en;
    logic grant;
    logic starve_hit;
    logic r0_acc, r1_acc, any_acc;

    // The entry can be replaced in the same cycle the pipeline takes it.
    assign load_en    = !valid_q || arb_ip_ready;
    // Readies are gated by rst so they stay low for the whole reset window,
    // not only from the first clock edge onwards.
    assign arb_en     = rst && load_en && !flush;
    assign starve_hit = (starve_q == STARVE_MAX);

    ip_arb_pick u_pick (
        .r0_valid_i   (r0_valid),
        .r1_valid_i   (r1_valid),
        .mode_fixed_i (MODE_FIXED),
        .last_grant_i (last_grant_q),
        .starve_hit_i (starve_hit),
        .grant_o      (grant)
    );

    assign r0_ready = arb_en && (grant == ARB_SRC_R0);
    assign r1_ready = arb_en && (grant == ARB_SRC_R1);
    assign r0_acc   = r0_valid && r0_ready;
    assign r1_acc   = r1_valid && r1_ready;
    assign any_acc  = r0_acc || r1_acc;

    always_comb begin
        payload_d    = payload_q;
        src_d        = src_q;
        valid_d      = valid_q;
        last_grant_d = last_grant_q;
        starve_d     = starve_q;
        stall_d      = stall_q;

        // Output stage: flush wins, then a fresh accept, then drain.
        if (!rst || flush) begin
            valid_d = 1'b0;
        end else if (any_acc) begin
            valid_d      = 1'b1;
            payload_d    = r1_acc ? r1_payload : r0_payload;
            src_d        = r1_acc ? ARB_SRC_R1 : ARB_SRC_R0;
            last_grant_d = r1_acc ? ARB_SRC_R1 : ARB_SRC_R0;
        end else if (load_en) begin
            valid_d = 1'b0;
        end

        // Starvation guard only exists in fixed-priority mode.
        if (PRIO_MODE == ARB_MODE_RR) begin
            starve_d = '0;
        end else if (r1_acc) begin
            starve_d = '0;
        end else if (r1_valid && arb_en && (grant != ARB_SRC_R1) && !starve_hit) begin
            starve_d = starve_q + 1'b1;
        end

        if ((r0_valid || r1_valid) && !any_acc && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    // NOTE: the wide payload register is reset too, so the pipeline never sees
    // X on arb_ip_payload straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            payload_q    <= '0;
            src_q        <= ARB_SRC_R0;
            valid_q      <= 1'b0;
            // Start as if r1 was granted last so r0 wins the first tie.
            last_grant_q <= ARB_SRC_R1;
            starve_q     <= '0;
            stall_q      <= '0;
        end else begin
            payload_q    <= payload_d;
            src_q        <= src_d;
            valid_q      <= valid_d;
            last_grant_q <= last_grant_d;
            starve_q     <= starve_d;
            stall_q      <= stall_d;
        end
    end

    assign arb_ip_payload = payload_q;
    assign arb_ip_src     = src_q;
    assign arb_ip_valid   = valid_q;
    assign arb_stall_cnt  = stall_q;

endmodule

// File: tb/tb_ip_issue_arb.sv
// tb_ip_issue_arb
// Directed bench for ip_issue_arb. Two instances share every input: u_rr in
// round-robin mode and u_fx in fixed-priority mode with STARVE_LIMIT = 4.
// Inputs change 1 time unit after the rising edge; readies are sampled 1
// unit later, registered outputs 1 unit after the next rising edge.
module tb_ip_issue_arb;

    localparam int PW = 256;

    logic          clk;
    logic          rst;
    logic [PW-1:0] r0_payload, r1_payload;
    logic          r0_valid, r1_valid;
    logic          flush;
    logic          ip_ready;

    logic          rr_r0_ready, rr_r1_ready, rr_src, rr_valid;
    logic [PW-1:0] rr_payload;
    logic [15:0]   rr_stall;
    logic          fx_r0_ready, fx_r1_ready, fx_src, fx_valid;
    logic [PW-1:0] fx_payload;
    logic [15:0]   fx_stall;

    int total = 0;
    int bad   = 0;

    ip_issue_arb #(.PAYLOAD_W(PW), .PRIO_MODE(0), .STARVE_LIMIT(4)) u_rr (
        .clk            (clk),
        .rst            (rst),
        .r0_payload     (r0_payload),
        .r0_valid       (r0_valid),
        .r0_ready       (rr_r0_ready),
        .r1_payload     (r1_payload),
        .r1_valid       (r1_valid),
        .r1_ready       (rr_r1_ready),
        .flush          (flush),
        .arb_ip_payload (rr_payload),
        .arb_ip_src     (rr_src),
        .arb_ip_valid   (rr_valid),
        .arb_ip_ready   (ip_ready),
        .arb_stall_cnt  (rr_stall)
    );

    ip_issue_arb #(.PAYLOAD_W(PW), .PRIO_MODE(1), .STARVE_LIMIT(4)) u_fx (
        .clk            (clk),
        .rst            (rst),
        .r0_payload     (r0_payload),
        .r0_valid       (r0_valid),
        .r0_ready       (fx_r0_ready),
        .r1_payload     (r1_payload),
        .r1_valid       (r1_valid),
        .r1_ready       (fx_r1_ready),
        .flush          (flush),
        .arb_ip_payload (fx_payload),
        .arb_ip_src     (fx_src),
        .arb_ip_valid   (fx_valid),
        .arb_ip_ready   (ip_ready),
        .arb_stall_cnt  (fx_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst      = 1'b0;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        flush    = 1'b0;
        ip_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [PW-1:0] exp_pl [4];
        logic [3:0]    exp_src;
        logic [9:0]    fx_pat;

        // Reset state, with requesters valid to show readies are held low.
        rst        = 1'b0;
        r0_valid   = 1'b1;
        r1_valid   = 1'b1;
        r0_payload = '0;
        r1_payload = '0;
        flush      = 1'b0;
        ip_ready   = 1'b1;
        tick();
        check("rst_valid",   rr_valid,    1'b0);
        check("rst_payload", rr_payload,  '0);
        check("rst_src",     rr_src,      1'b0);
        check("rst_stall",   rr_stall,    16'd0);
        check("rst_r0_rdy",  rr_r0_ready, 1'b0);
        check("rst_r1_rdy",  rr_r1_ready, 1'b0);

        // Round-robin, both valid: r0, r1, r0, r1 with no bubble.
        rst_pulse();
        r0_valid   = 1'b1;
        r1_valid   = 1'b1;
        ip_ready   = 1'b1;
        r0_payload = 'hA0;
        r1_payload = 'hB0;
        exp_pl     = '{'hA0, 'hB0, 'hA1, 'hB1};
        exp_src    = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_r0_rdy", rr_r0_ready, !exp_src[i]);
            check("rr_r1_rdy", rr_r1_ready, exp_src[i]);
            tick();
            check("rr_valid",   rr_valid,   1'b1);
            check("rr_src",     rr_src,     exp_src[i]);
            check("rr_payload", rr_payload, exp_pl[i]);
            if (exp_src[i]) r1_payload = r1_payload + 1;
            else            r0_payload = r0_payload + 1;
        end

        // Backpressure: entry 0xA5 from r0 held for 3 cycles, r1 waiting.
        rst_pulse();
        r0_valid   = 1'b1;
        r0_payload = 'hA5;
        ip_ready   = 1'b1;
        tick();
        r0_valid   = 1'b0;
        r1_valid   = 1'b1;
        r1_payload = 'hB7;
        ip_ready   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_r0_rdy", rr_r0_ready, 1'b0);
            check("bp_r1_rdy", rr_r1_ready, 1'b0);
            tick();
            check("bp_valid",   rr_valid,   1'b1);
            check("bp_src",     rr_src,     1'b0);
            check("bp_payload", rr_payload, 'hA5);
        end
        check("bp_stall", rr_stall, 16'd3);
        ip_ready = 1'b1;
        #1;
        check("bp_rel_r1_rdy", rr_r1_ready, 1'b1);
        tick();
        check("bp_rel_src",     rr_src,     1'b1);
        check("bp_rel_payload", rr_payload, 'hB7);

        // Fixed priority, STARVE_LIMIT 4: r0 x4, r1, r0 x4, r1.
        rst_pulse();
        r0_valid   = 1'b1;
        r1_valid   = 1'b1;
        ip_ready   = 1'b1;
        r0_payload = 'hA0;
        r1_payload = 'hB0;
        fx_pat     = 10'b10000_10000;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("fx_r1_rdy", fx_r1_ready, fx_pat[i]);
            tick();
            check("fx_valid", fx_valid, 1'b1);
            check("fx_src",   fx_src,   fx_pat[i]);
        end

        // Flush with a held entry under backpressure.
        rst_pulse();
        r0_valid   = 1'b1;
        r1_valid   = 1'b1;
        ip_ready   = 1'b1;
        r0_payload = 'hA0;
        r1_payload = 'hB0;
        tick();
        check("fl_pre_src", rr_src, 1'b0);
        ip_ready = 1'b0;
        flush    = 1'b1;
        #1;
        check("fl_r0_rdy", rr_r0_ready, 1'b0);
        check("fl_r1_rdy", rr_r1_ready, 1'b0);
        tick();
        check("fl_valid", rr_valid, 1'b0);
        flush    = 1'b0;
        ip_ready = 1'b1;
        #1;
        check("fl_next_r0_rdy", rr_r0_ready, 1'b0);
        check("fl_next_r1_rdy", rr_r1_ready, 1'b1);
        tick();
        check("fl_next_src",     rr_src,     1'b1);
        check("fl_next_payload", rr_payload, 'hB0);
        // Flush while the stage could load: nothing is consumed.
        flush = 1'b1;
        #1;
        check("fl2_r0_rdy", rr_r0_ready, 1'b0);
        check("fl2_r1_rdy", rr_r1_ready, 1'b0);
        tick();
        check("fl2_valid", rr_valid, 1'b0);
        flush = 1'b0;
        #1;
        check("fl2_next_r0_rdy", rr_r0_ready, 1'b1);
        tick();
        check("fl2_next_src", rr_src, 1'b0);

        // r1 only: five back-to-back ops.
        rst_pulse();
        r1_valid = 1'b1;
        ip_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r1_payload = PW'('hC0 + i);
            #1;
            check("r1o_r0_rdy", rr_r0_ready, 1'b0);
            check("r1o_r1_rdy", rr_r1_ready, 1'b1);
            tick();
            check("r1o_valid",   rr_valid,   1'b1);
            check("r1o_src",     rr_src,     1'b1);
            check("r1o_payload", rr_payload, PW'('hC0 + i));
        end

        // Async reset pulse while the stage holds an entry.
        ip_ready = 1'b0;
        tick();
        tick();
        check("ar_pre_valid", rr_valid, 1'b1);
        check("ar_pre_stall", rr_stall, 16'd2);
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid",  rr_valid,    1'b0);
        check("ar_stall",  rr_stall,    16'd0);
        check("ar_r1_rdy", rr_r1_ready, 1'b0);
        r1_valid = 1'b0;
        #1;
        rst = 1'b1;
        tick();
        check("ar_post_valid", rr_valid, 1'b0);
        r0_valid   = 1'b1;
        r0_payload = 'hD0;
        #1;
        check("ar_post_r0_rdy", rr_r0_ready, 1'b1);
        tick();
        check("ar_post_src",     rr_src,     1'b0);
        check("ar_post_payload", rr_payload, 'hD0);
        check("ar_post_valid1",  rr_valid,   1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ip_issue_arb.md
Name: ip_issue_arb

Overview:
- Arbitrates between two issue sources for the single integer pipeline: primary issue slot (r0) and secondary/replay slot (r1).
- Sits between the issue stage and the integer pipeline input handshake.
- Registers the granted request in a one-entry output stage: 1-cycle latency, 1 op/cycle throughput.
- Supports round-robin or fixed-priority arbitration with a starvation guard, plus flush on a branch redirect.

Parameters:
PAYLOAD_W, 256, width of the opaque packed issue bundle (pc, dst, op, operands, bp/bt, ...)
PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority r0 with r1 starvation guard
STARVE_LIMIT, 4, in PRIO_MODE 1: cycles r1 may lose while the stage can load before a forced r1 grant (1..7)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset (asserted when 0)
r0_payload  input  PAYLOAD_W  requester 0 bundle
r0_valid  input  1  requester 0 valid
r0_ready  output  1  requester 0 accepted this cycle when r0_valid && r0_ready
r1_payload  input  PAYLOAD_W  requester 1 bundle
r1_valid  input  1  requester 1 valid
r1_ready  output  1  requester 1 accepted this cycle when r1_valid && r1_ready
flush  input  1  pipeline redirect (driven from pc override); kills held and incoming ops
arb_ip_payload  output  PAYLOAD_W  registered bundle to integer pipeline
arb_ip_src  output  1  source of arb_ip_payload (0 = r0, 1 = r1)
arb_ip_valid  output  1  output entry valid
arb_ip_ready  input  1  integer pipeline accepts the entry
arb_stall_cnt  output  16  saturating count of cycles with any requester valid but no acceptance

Behaviour:
- Reset (rst = 0, async):
  - arb_ip_valid = 0, arb_ip_payload = 0, arb_ip_src = 0.
  - last_grant = 1, so r0 wins the first round-robin tie.
  - starve_cnt = 0, arb_stall_cnt = 0.
  - r0_ready and r1_ready are 0 while reset is asserted.
- load_en = !arb_ip_valid || arb_ip_ready.
  - The output entry may be replaced in the same cycle it is consumed.
  - No bubble is inserted at full throughput.
- Grant (combinational, evaluated only when load_en && !flush):
  - Only one valid requester: it wins.
  - Both valid, PRIO_MODE 0: winner = !last_grant. last_grant updates to the winner on every accept.
  - Both valid, PRIO_MODE 1: r0 wins unless starve_cnt == STARVE_LIMIT, in which case r1 wins.
- Ready outputs:
  - rX_ready = load_en && !flush && (grant == X).
  - At most one ready is high per cycle.
  - A ready never depends on its own rX_valid. It may depend on the other requester's valid.
- Accept: on rX_valid && rX_ready, the next cycle has arb_ip_payload = rX_payload, arb_ip_src = X, arb_ip_valid = 1.
- Output without acceptance:
  - load_en && no accept → arb_ip_valid <= 0.
  - !load_en → payload, src and valid hold unchanged (stable under backpressure).
- starve_cnt (PRIO_MODE 1 only; held at 0 in mode 0):
  - Increments, saturating at STARVE_LIMIT, on cycles with r1_valid && load_en && !flush && r1 not granted.
  - Clears on an r1 accept.
  - Holds otherwise.
- flush (highest precedence):
  - arb_ip_valid <= 0 next cycle, regardless of arb_ip_ready.
  - Both readies are 0 in the flush cycle; no request is consumed.
  - last_grant and starve_cnt hold.
- arb_stall_cnt increments, saturating at 0xFFFF, when (r0_valid || r1_valid) && !(r0 accept || r1 accept).
- Requesters must hold their payload stable while valid and not accepted; this arbiter does not buffer them.
- Reset asserted mid-operation drops any held entry with no handshake completion. The first post-reset cycle behaves as an empty stage.

Decomposition:
- Shared defines header (alongside the existing BT_*/ALU_* defines):
  - ARB_SRC_R0 / ARB_SRC_R1 constants.
  - ARB_MODE_RR / ARB_MODE_FIXED constants.
- Sub-module ip_arb_pick: purely combinational 2-way grant from (valids, mode, last_grant, starve_hit).
  - Kept separate so it can be reused by a later 2-way LSU port arbiter.
- Registers (output stage, last_grant, counters) live in ip_issue_arb.

Test Plan:
- Reset release, PRIO_MODE 0, both valid, arb_ip_ready = 1 for 4 cycles → grants r0, r1, r0, r1; arb_ip_src sequence 0, 1, 0, 1 one cycle after each accept; arb_ip_valid continuously 1 with no bubble.
- Backpressure: entry holds payload 0xA5 from r0, arb_ip_ready = 0 for 3 cycles → both readies 0, payload/src/valid stable; arb_stall_cnt = 3 if r1 valid throughout.
- PRIO_MODE 1, STARVE_LIMIT = 4, both valid, ready = 1 → r0 granted 4 cycles, r1 granted on the 5th, starve_cnt back to 0, then r0 again.
- Flush while arb_ip_valid = 1, arb_ip_ready = 0, both requesters valid → readies 0 that cycle; arb_ip_valid = 0 next cycle; next accept follows unchanged last_grant.
- Single requester r1 only, 5 back-to-back ops with ready = 1 → all 5 accepted on consecutive cycles, src = 1, and r0_ready stays 0 throughout.
- Async reset pulse (rst = 0 for half a cycle) while the stage holds a valid entry → arb_ip_valid drops immediately without waiting for a clock edge, and arb_stall_cnt = 0 afterwards.
